// File: rtl/axi_wr_pkg.sv
// Shared types and constants for the 2-master AXI write-path arbiter.
package axi_wr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AW   = 2'd1,
        W    = 2'd2,
        B    = 2'd3
    } wr_state_t;

    localparam logic GNT_M0 = 1'b0;
    localparam logic GNT_M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin picker: a lone requester wins, a tie goes
// to the master that was not served last.
module rr_arb2
    import axi_wr_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);

    always_comb begin
        winner = GNT_M0;
        if (req == 2'b11) begin
            winner = ~last;
        end else if (req == 2'b10) begin
            winner = GNT_M1;
        end
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Write-path owner controller for a 2-master AXI interconnect: AW/W/B steering
// plus the registered W-mux select. Define AXI_W_LEN_CHECK_EN for burst-length checking.
module axi_wr_arbiter
    import axi_wr_pkg::*;
#(
    parameter int unsigned LEN_BITS  = 4,
    parameter logic        INIT_LAST = 1'b1
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                AWVALID_M0,
    input  logic                AWVALID_M1,
    input  logic [LEN_BITS-1:0] AWLEN_M0,
    input  logic [LEN_BITS-1:0] AWLEN_M1,
    output logic                AWREADY_M0,
    output logic                AWREADY_M1,
    output logic                AWVALID_S,
    input  logic                AWREADY_S,
    input  logic                WVALID,
    input  logic                WLAST,
    input  logic                WREADY_S,
    output logic                WREADY_M0,
    output logic                WREADY_M1,
    input  logic                BVALID_S,
    output logic                BREADY_S,
    output logic                BVALID_M0,
    output logic                BVALID_M1,
    input  logic                BREADY_M0,
    input  logic                BREADY_M1,
    output logic                gnt,
    output logic                wlast_err
);

    wr_state_t state_q, state_d;
    logic      gnt_q, gnt_d;
    logic      last_q, last_d;
    logic      winner;
    logic      awValidSel, bReadySel;
    logic      awFire, wFire, bFire;

    rr_arb2 u_rr_arb2 (
        .req    ({AWVALID_M1, AWVALID_M0}),
        .last   (last_q),
        .winner (winner)
    );

    assign awValidSel = (gnt_q == GNT_M1) ? AWVALID_M1 : AWVALID_M0;
    assign bReadySel  = (gnt_q == GNT_M1) ? BREADY_M1  : BREADY_M0;
    assign awFire     = (state_q == AW) && awValidSel && AWREADY_S;
    assign wFire      = (state_q == W)  && WVALID && WREADY_S;
    assign bFire      = (state_q == B)  && BVALID_S && bReadySel;
    assign gnt        = gnt_q;

    // Handshakes are decoded from state so the non-owner never sees a ready/valid.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        AWVALID_S  = 1'b0;
        AWREADY_M0 = 1'b0;
        AWREADY_M1 = 1'b0;
        WREADY_M0  = 1'b0;
        WREADY_M1  = 1'b0;
        BREADY_S   = 1'b0;
        BVALID_M0  = 1'b0;
        BVALID_M1  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (AWVALID_M0 || AWVALID_M1) begin
                    gnt_d   = winner;
                    state_d = AW;
                end
            end
            AW: begin
                AWVALID_S  = awValidSel;
                AWREADY_M0 = (gnt_q == GNT_M0) && AWREADY_S;
                AWREADY_M1 = (gnt_q == GNT_M1) && AWREADY_S;
                if (awFire) begin
                    state_d = W;
                end
            end
            W: begin
                WREADY_M0 = (gnt_q == GNT_M0) && WREADY_S;
                WREADY_M1 = (gnt_q == GNT_M1) && WREADY_S;
                if (wFire && WLAST) begin
                    state_d = B;
                end
            end
            B: begin
                BREADY_S  = bReadySel;
                BVALID_M0 = (gnt_q == GNT_M0) && BVALID_S;
                BVALID_M1 = (gnt_q == GNT_M1) && BVALID_S;
                if (bFire) begin
                    last_d  = gnt_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            gnt_q   <= GNT_M0;
            last_q  <= INIT_LAST;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

`ifdef AXI_W_LEN_CHECK_EN
    localparam logic [LEN_BITS:0] CNT_ONE = {{LEN_BITS{1'b0}}, 1'b1};

    logic [LEN_BITS:0]   cnt_q, cnt_d;
    logic [LEN_BITS-1:0] len_q, len_d;
    logic                err_q, err_d;

    // Count is the zero-based index of the beat being accepted, compared to AWLEN.
    always_comb begin
        cnt_d = cnt_q;
        len_d = len_q;
        err_d = 1'b0;
        if (awFire) begin
            cnt_d = '0;
            len_d = (gnt_q == GNT_M1) ? AWLEN_M1 : AWLEN_M0;
        end else if (wFire) begin
            err_d = WLAST ? (cnt_q != {1'b0, len_q}) : (cnt_q == {1'b0, len_q});
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cnt_q <= '0;
            len_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            len_q <= len_d;
            err_q <= err_d;
        end
    end

    assign wlast_err = err_q;
`else
    logic unusedAwLen;
    assign unusedAwLen = ^{AWLEN_M0, AWLEN_M1};
    assign wlast_err   = 1'b0;
`endif

endmodule
